s1_acc_stage: RTL and testbench

S1_ACC_STAGE -- requirements
Module: s1_acc_stage

---
 rtl/s1_acc_pkg.sv | 20 ++
 rtl/s1_mode_dec.sv | 17 +
 rtl/s1_acc_stage.sv | 106 ++++++++++
 tb/tb_s1_acc_stage.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/s1_acc_pkg.sv
// Shared encodings for the S1 accumulator stage: the 2-bit mode code
// produced by the Actel-style decoder and the three-state FSM encoding.
package s1_acc_pkg;

    // Mode code {M1,M0}: 00 hold, 01 load, 10 increment, 11 decrement.
    typedef enum logic [1:0] {
        HOLD = 2'b00,
        LOAD = 2'b01,
        INC  = 2'b10,
        DEC  = 2'b11
    } mode_t;

    // Counter state: IDLE after reset, ACTIVE after a load, OVFL after wrap/saturation.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACTIVE = 2'b01,
        OVFL   = 2'b10
    } state_t;

endpackage

// File: rtl/s1_mode_dec.sv
// Actel-style mode decode: M1 = A1 | B1, M0 = A0. Purely combinational.
module s1_mode_dec
    import s1_acc_pkg::*;
(
    input  logic  i_a1,
    input  logic  i_b1,
    input  logic  i_a0,
    output mode_t o_mode
);

    logic w_m1;

    // Either upper select line requests a counting mode.
    assign w_m1   = i_a1 | i_b1;
    assign o_mode = mode_t'({w_m1, i_a0});

endmodule

// File: rtl/s1_acc_stage.sv
// S1 accumulator stage: loadable up/down counter with a three-state FSM
// (IDLE / ACTIVE / OVFL), sticky overflow flag and combinational terminal
// count. Build option: define S1_ACC_SAT_EN to saturate instead of wrap at
// the counter limits; the overflow event is flagged either way.
module s1_acc_stage
    import s1_acc_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         CLK,
    input  logic         CLRn,
    input  logic [N-1:0] DIN,
    input  logic         DIN_VALID,
    input  logic         A1,
    input  logic         B1,
    input  logic         A0,
    input  logic         EN,
    output logic [N-1:0] Q,
    output logic         Q_VALID,
    output logic         TC,
    output logic         OVF
);

    state_t       r_state;
    logic [N-1:0] r_q;
    logic         r_q_valid;
    logic         r_ovf;

    mode_t        w_mode;
    logic         w_active;
    logic         w_at_max;
    logic         w_at_zero;
    logic [N-1:0] w_q_up;
    logic [N-1:0] w_q_dn;

    s1_mode_dec u_mode_dec (
        .i_a1   (A1),
        .i_b1   (B1),
        .i_a0   (A0),
        .o_mode (w_mode)
    );

    assign w_active  = (r_state != IDLE);
    assign w_at_max  = (r_q == {N{1'b1}});
    assign w_at_zero = (r_q == '0);

`ifdef S1_ACC_SAT_EN
    // Saturating step: the limit value is held when the step would cross it.
    assign w_q_up = w_at_max  ? r_q : r_q + N'(1);
    assign w_q_dn = w_at_zero ? r_q : r_q - N'(1);
`else
    // Wrapping step: plain modulo-2^N arithmetic.
    assign w_q_up = r_q + N'(1);
    assign w_q_dn = r_q - N'(1);
`endif

    // FSM and datapath: load, count or hold on each enabled edge; async clear.
    // NOTE: every register here uses <= so all updates see the pre-edge values.
    always_ff @(posedge CLK or negedge CLRn) begin
        if (!CLRn) begin
            r_q       <= '0;
            r_state   <= IDLE;
            r_q_valid <= 1'b0;
            r_ovf     <= 1'b0;
        end else if (EN) begin
            case (w_mode)
                LOAD: begin
                    if (DIN_VALID) begin
                        r_q       <= DIN;
                        r_state   <= ACTIVE;
                        r_q_valid <= 1'b1;
                        r_ovf     <= 1'b0;
                    end
                end
                INC: begin
                    if (w_active) begin
                        r_q <= w_q_up;
                        if (w_at_max) begin
                            r_state <= OVFL;
                            r_ovf   <= 1'b1;
                        end
                    end
                end
                DEC: begin
                    if (w_active) begin
                        r_q <= w_q_dn;
                        if (w_at_zero) begin
                            r_state <= OVFL;
                            r_ovf   <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Terminal count looks at the live mode inputs, so it reacts before the edge.
    assign TC = w_active && (((w_mode == INC) && w_at_max) ||
                             ((w_mode == DEC) && w_at_zero));

    assign Q       = r_q;
    assign Q_VALID = r_q_valid;
    assign OVF     = r_ovf;

endmodule

// File: tb/tb_s1_acc_stage.sv
// Directed, table-driven bench for s1_acc_stage (N=4). Expected values are
// hand-computed; wrap versus saturation expectations follow S1_ACC_SAT_EN.
`timescale 1ns/1ps
module tb_s1_acc_stage;

    localparam int N  = 4;
    localparam int NV = 19;

`ifdef S1_ACC_SAT_EN
    localparam logic [N-1:0] UP_WRAP_Q = 4'hF;
    localparam logic [N-1:0] DN_WRAP_Q = 4'h0;
    localparam logic         SAT       = 1'b1;
`else
    localparam logic [N-1:0] UP_WRAP_Q = 4'h0;
    localparam logic [N-1:0] DN_WRAP_Q = 4'hF;
    localparam logic         SAT       = 1'b0;
`endif

    logic         CLK;
    logic         CLRn;
    logic [N-1:0] DIN;
    logic         DIN_VALID;
    logic         A1, B1, A0;
    logic         EN;
    logic [N-1:0] Q;
    logic         Q_VALID;
    logic         TC;
    logic         OVF;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic         en;
        logic [N-1:0] din;
        logic         dv;
        logic         a1;
        logic         b1;
        logic         a0;
        logic [N-1:0] q;
        logic         qv;
        logic         tc;
        logic         ovf;
    } vec_t;

    vec_t vecs [NV];

    s1_acc_stage #(.N(N)) dut (
        .CLK       (CLK),
        .CLRn      (CLRn),
        .DIN       (DIN),
        .DIN_VALID (DIN_VALID),
        .A1        (A1),
        .B1        (B1),
        .A0        (A0),
        .EN        (EN),
        .Q         (Q),
        .Q_VALID   (Q_VALID),
        .TC        (TC),
        .OVF       (OVF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic en, input logic [N-1:0] din, input logic dv,
                         input logic a1, input logic b1, input logic a0);
        EN        = en;
        DIN       = din;
        DIN_VALID = dv;
        A1        = a1;
        B1        = b1;
        A0        = a0;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [N-1:0] q, input logic qv,
                              input logic tc, input logic ovf);
        check({tag, ".Q"},       int'(Q),       int'(q));
        check({tag, ".Q_VALID"}, int'(Q_VALID), int'(qv));
        check({tag, ".TC"},      int'(TC),      int'(tc));
        check({tag, ".OVF"},     int'(OVF),     int'(ovf));
    endtask

    initial begin
        //           en    din    dv    a1    b1    a0    q      qv    tc    ovf
        // IDLE gating: increments and a decrement are ignored, TC stays 0.
        vecs[0]  = '{1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0};
        // Load D then increment through F to the wrap / saturation point.
        vecs[4]  = '{1'b1, 4'hD, 1'b1, 1'b0, 1'b0, 1'b1, 4'hD, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 4'hE, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 4'hF, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, UP_WRAP_Q, 1'b1, SAT, 1'b1};
        // Load 1, decrement twice (B1/A0 decode to DEC), then reload 5.
        vecs[8]  = '{1'b1, 4'h1, 1'b1, 1'b0, 1'b0, 1'b1, 4'h1, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, DN_WRAP_Q, 1'b1, SAT, 1'b1};
        vecs[11] = '{1'b1, 4'h5, 1'b1, 1'b0, 1'b0, 1'b1, 4'h5, 1'b1, 1'b0, 1'b0};
        // Load without valid, then EN=0 freezes increments and loads.
        vecs[12] = '{1'b1, 4'hA, 1'b0, 1'b0, 1'b0, 1'b1, 4'h5, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h5, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h5, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 4'h3, 1'b1, 1'b0, 1'b0, 1'b1, 4'h5, 1'b1, 1'b0, 1'b0};
        // Load F; with EN=0 TC still follows Q and mode.
        vecs[16] = '{1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 4'hF, 1'b1, 1'b1, 1'b0};
        // A1=1,B1=1,A0=0 decodes to INC: wrap / saturate from F into OVFL.
        vecs[18] = '{1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, UP_WRAP_Q, 1'b1, SAT, 1'b1};

        // Reset state, checked with no clock edge needed.
        CLRn = 1'b0;
        drive(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        check_outs("reset", 4'h0, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        CLRn = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].en, vecs[i].din, vecs[i].dv, vecs[i].a1, vecs[i].b1, vecs[i].a0);
            step();
            check_outs($sformatf("vec%0d", i), vecs[i].q, vecs[i].qv, vecs[i].tc, vecs[i].ovf);
        end

        // Count to Q=7 while staying in OVFL.
`ifdef S1_ACC_SAT_EN
        drive(1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) step();
`else
        drive(1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step();
`endif
        check("ovfl_count.Q",   int'(Q),   7);
        check("ovfl_count.OVF", int'(OVF), 1);

        // A mode pulse between edges must not change state.
        drive(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        drive(1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        #2;
        drive(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check("glitch.Q",   int'(Q),   7);
        check("glitch.OVF", int'(OVF), 1);

        // Asynchronous clear mid-cycle, observed before any edge.
        drive(1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        #2;
        CLRn = 1'b0;
        #1;
        check_outs("async_clr", 4'h0, 1'b0, 1'b0, 1'b0);

        // First edge after release is a normal operating edge.
        @(negedge CLK);
        drive(1'b1, 4'h9, 1'b1, 1'b0, 1'b0, 1'b1);
        CLRn = 1'b1;
        step();
        check_outs("post_clr_load", 4'h9, 1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
